mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-access (MEM) stage of the five-stage MIPS pipeline, directly downstream of the execute stage. Latches the EXE-stage ALU result, store value and control bits, and performs data-memory loads and stores on an internal word array with configurable multi-cycle latency. During an access it freezes upstream stages. Registered MEM/WB outputs and the final write-back result feed the register file and the hazard/forwarding logic.

## Interface
- WORD_LEN, 32, data/address word width
- REG_FILE_ADDR_LEN, 5, destination register index width
- DMEM_DEPTH, 64, data memory size in words (power of two)
- MEM_LAT, 2, cycles per load/store access (≥1)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  EXE stage presents an instruction this cycle
- ALURes_EXE  in  WORD_LEN  ALU result; byte address for LD/ST
- ST_value_EXE  in  WORD_LEN  store data
- dest_EXE  in  REG_FILE_ADDR_LEN  destination register
- WB_EN_EXE, MEM_R_EN_EXE, MEM_W_EN_EXE  in  1 each  control bits
- freeze  out  1  upstream must hold its outputs this cycle
- dest_MEM, WB_EN_MEM  out  5/1  instruction currently in MEM, used by the hazard unit
- ALURes_WB, dataMem_out_WB  out  WORD_LEN  registered MEM/WB values
- dest_WB  out  REG_FILE_ADDR_LEN; WB_EN_WB, MEM_R_EN_WB  out  1
- WB_result  out  WORD_LEN  MEM_R_EN_WB ? dataMem_out_WB : ALURes_WB (combinational from registers)
- misalign_err  out  1  see Configuration

## Operation
- Word index = ALURes_EXE[log2(DMEM_DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo DMEM_DEPTH.
- FSM states:
  - IDLE: accepts in_valid. A non-memory op loads the WB registers at the next edge.
  - LD/ST with MEM_LAT=1 behaves the same way; the store commits at the same edge.
  - LD/ST with MEM_LAT>1 latches the inputs, sets cnt=MEM_LAT-1 and moves to BUSY.
- BUSY: freeze=1 and in_valid is ignored; cnt decrements each cycle. On the edge where cnt==1:
  - the store commits;
  - the load reads the array;
  - the WB registers load;
  - the FSM returns to IDLE.
- dest_MEM/WB_EN_MEM reflect the latched instruction in BUSY. In IDLE they reflect the EXE inputs; WB_EN_MEM=0 when in_valid=0.
- WB registers during BUSY, and after an IDLE cycle with in_valid=0, hold a bubble: WB_EN_WB=0, MEM_R_EN_WB=0.
- MEM_R_EN and MEM_W_EN both set: the store commits, the load returns the pre-write word, and WB_EN passes through unchanged.
- A store followed by a load to the same word returns the new value.
- Memory contents are undefined at power-up and are not cleared by rst.

## Timing
- Reset (synchronous) clears:
  - state=IDLE, cnt=0;
  - freeze=0, misalign_err=0;
  - WB_EN_WB=0, MEM_R_EN_WB=0;
  - ALURes_WB, dataMem_out_WB and dest_WB all 0.
- rst during BUSY aborts the access: a store that has not yet reached its commit edge is not written.
- Latency:
  - non-memory op: accepted at edge n, WB outputs valid from n+1;
  - LD/ST: freeze high in cycles n+1 … n+MEM_LAT-1, WB outputs valid from n+MEM_LAT, next instruction accepted at edge n+MEM_LAT.
- freeze is a function of state only, never combinational from the inputs.

## Configuration
- MEM_MISALIGN_CHK_EN defined: an LD/ST with ALURes_EXE[1:0]≠0 still takes MEM_LAT cycles, but:
  - the array is not written;
  - WB_EN_WB is forced to 0 for that instruction;
  - misalign_err=1 for exactly the one cycle its WB outputs are presented.
- Undefined: misalign_err is tied 0 and address bits [1:0] are ignored.

## Test plan
- Reset, then ADD result 0x0000_0055 to r3 (MEM_LAT=2) → next cycle WB_result=0x55, dest_WB=3, WB_EN_WB=1, freeze never asserted.
- ST 0xDEAD_BEEF to addr 0x10, then LD from 0x10 to r7 (MEM_LAT=2) →
  - freeze high one cycle per op;
  - WB_result=0xDEAD_BEEF, WB_EN_WB=1, dest_WB=7, MEM_R_EN_WB=1.
- ST to addr 0x100+0x10 with DMEM_DEPTH=64 → wraps; an LD from 0x10 returns the stored word.
- MEM_LAT=3, LD issued and rst asserted in the second freeze cycle → all outputs at reset values next cycle. A store interrupted the same way leaves the old memory word intact.
- With MEM_MISALIGN_CHK_EN: ST to 0x12 → memory word 4 unchanged, misalign_err pulses 1 cycle, WB_EN_WB=0. Without the macro: word 4 is written and misalign_err stays 0.

Source files
------------

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MIPS MEM stage: multi-cycle data memory access with upstream freeze.
// Optional build macro: MEM_MISALIGN_CHK_EN (suppress and flag LD/ST with ALURes_EXE[1:0] != 0).
module mem_access_stage #(
    parameter int WORD_LEN          = 32,
    parameter int REG_FILE_ADDR_LEN = 5,
    parameter int DMEM_DEPTH        = 64,
    parameter int MEM_LAT           = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [WORD_LEN-1:0]          ALURes_EXE,
    input  logic [WORD_LEN-1:0]          ST_value_EXE,
    input  logic [REG_FILE_ADDR_LEN-1:0] dest_EXE,
    input  logic                         WB_EN_EXE,
    input  logic                         MEM_R_EN_EXE,
    input  logic                         MEM_W_EN_EXE,
    output logic                         freeze,
    output logic [REG_FILE_ADDR_LEN-1:0] dest_MEM,
    output logic                         WB_EN_MEM,
    output logic [WORD_LEN-1:0]          ALURes_WB,
    output logic [WORD_LEN-1:0]          dataMem_out_WB,
    output logic [REG_FILE_ADDR_LEN-1:0] dest_WB,
    output logic                         WB_EN_WB,
    output logic                         MEM_R_EN_WB,
    output logic [WORD_LEN-1:0]          WB_result,
    output logic                         misalign_err
);
    localparam int ADDR_W = $clog2(DMEM_DEPTH);
    localparam int CNT_W  = $clog2(MEM_LAT + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                         state, state_next;
    logic [CNT_W-1:0]               cnt, cnt_next;
    logic                           commit, latch_en;

    logic [WORD_LEN-1:0]            lat_alu, lat_st;
    logic [REG_FILE_ADDR_LEN-1:0]   lat_dest;
    logic                           lat_wb, lat_r, lat_w;

    // Instruction being committed this edge: EXE inputs in IDLE, latched copy in BUSY.
    logic [WORD_LEN-1:0]            c_alu, c_st;
    logic [REG_FILE_ADDR_LEN-1:0]   c_dest;
    logic                           c_wb, c_r, c_w, c_mis;
    logic [ADDR_W-1:0]              c_idx;
    logic                           mem_we;
    logic                           unused_bits;

    logic [WORD_LEN-1:0]            mem [DMEM_DEPTH];

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        commit     = 1'b0;
        latch_en   = 1'b0;
        c_alu      = ALURes_EXE;
        c_st       = ST_value_EXE;
        c_dest     = dest_EXE;
        c_wb       = WB_EN_EXE;
        c_r        = MEM_R_EN_EXE;
        c_w        = MEM_W_EN_EXE;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if ((MEM_R_EN_EXE || MEM_W_EN_EXE) && (MEM_LAT > 1)) begin
                        latch_en   = 1'b1;
                        state_next = BUSY;
                        cnt_next   = CNT_W'(MEM_LAT - 1);
                    end else begin
                        commit = 1'b1;
                    end
                end
            end
            BUSY: begin
                c_alu  = lat_alu;
                c_st   = lat_st;
                c_dest = lat_dest;
                c_wb   = lat_wb;
                c_r    = lat_r;
                c_w    = lat_w;
                if (cnt == CNT_W'(1)) begin
                    commit     = 1'b1;
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef MEM_MISALIGN_CHK_EN
    assign c_mis = (c_r || c_w) && (c_alu[1:0] != 2'b00);
`else
    assign c_mis = 1'b0;
`endif

    assign c_idx       = c_alu[ADDR_W+1:2];
    assign mem_we      = commit && c_w && !c_mis && !rst;
    assign unused_bits = ^{c_alu[WORD_LEN-1:ADDR_W+2], c_alu[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (latch_en) begin
            lat_alu  <= ALURes_EXE;
            lat_st   <= ST_value_EXE;
            lat_dest <= dest_EXE;
            lat_wb   <= WB_EN_EXE;
            lat_r    <= MEM_R_EN_EXE;
            lat_w    <= MEM_W_EN_EXE;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[c_idx] <= c_st;
        end
    end

    // Reading mem here returns the pre-write word when a combined LD/ST commits.
    always_ff @(posedge clk) begin
        if (rst) begin
            ALURes_WB      <= '0;
            dataMem_out_WB <= '0;
            dest_WB        <= '0;
            WB_EN_WB       <= 1'b0;
            MEM_R_EN_WB    <= 1'b0;
        end else if (commit) begin
            ALURes_WB   <= c_alu;
            dest_WB     <= c_dest;
            WB_EN_WB    <= c_wb && !c_mis;
            MEM_R_EN_WB <= c_r;
            if (c_r) begin
                dataMem_out_WB <= mem[c_idx];
            end
        end else begin
            WB_EN_WB    <= 1'b0;
            MEM_R_EN_WB <= 1'b0;
        end
    end

`ifdef MEM_MISALIGN_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= commit && c_mis;
        end
    end
`else
    assign misalign_err = 1'b0;
`endif

    assign freeze    = (state == BUSY);
    assign dest_MEM  = (state == BUSY) ? lat_dest : dest_EXE;
    assign WB_EN_MEM = (state == BUSY) ? lat_wb : (WB_EN_EXE && in_valid);
    assign WB_result = MEM_R_EN_WB ? dataMem_out_WB : ALURes_WB;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - Randomized self-checking bench for mem_access_stage (MEM_LAT 2 and 3).
module tb_mem_access_stage;
`ifdef MEM_MISALIGN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst2, rst3, use3;
    logic        in_valid, wb, re, wr;
    logic [31:0] alu, st_val;
    logic [4:0]  dest;

    logic        f2, wbm2, wbwb2, rwb2, me2, f3, wbm3, wbwb3, rwb3, me3;
    logic [4:0]  dm2, dwb2, dm3, dwb3;
    logic [31:0] aw2, dw2, res2, aw3, dw3, res3;

    logic        o_freeze, o_wbm, o_wbwb, o_rwb, o_me;
    logic [4:0]  o_dm, o_dwb;
    logic [31:0] o_aw, o_dw, o_res;

    logic [31:0] mem_m [64];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.MEM_LAT(2)) dut2 (
        .clk(clk), .rst(rst2), .in_valid(in_valid), .ALURes_EXE(alu), .ST_value_EXE(st_val),
        .dest_EXE(dest), .WB_EN_EXE(wb), .MEM_R_EN_EXE(re), .MEM_W_EN_EXE(wr),
        .freeze(f2), .dest_MEM(dm2), .WB_EN_MEM(wbm2), .ALURes_WB(aw2), .dataMem_out_WB(dw2),
        .dest_WB(dwb2), .WB_EN_WB(wbwb2), .MEM_R_EN_WB(rwb2), .WB_result(res2), .misalign_err(me2)
    );

    mem_access_stage #(.MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst3), .in_valid(in_valid), .ALURes_EXE(alu), .ST_value_EXE(st_val),
        .dest_EXE(dest), .WB_EN_EXE(wb), .MEM_R_EN_EXE(re), .MEM_W_EN_EXE(wr),
        .freeze(f3), .dest_MEM(dm3), .WB_EN_MEM(wbm3), .ALURes_WB(aw3), .dataMem_out_WB(dw3),
        .dest_WB(dwb3), .WB_EN_WB(wbwb3), .MEM_R_EN_WB(rwb3), .WB_result(res3), .misalign_err(me3)
    );

    assign o_freeze = use3 ? f3    : f2;
    assign o_wbm    = use3 ? wbm3  : wbm2;
    assign o_wbwb   = use3 ? wbwb3 : wbwb2;
    assign o_rwb    = use3 ? rwb3  : rwb2;
    assign o_me     = use3 ? me3   : me2;
    assign o_dm     = use3 ? dm3   : dm2;
    assign o_dwb    = use3 ? dwb3  : dwb2;
    assign o_aw     = use3 ? aw3   : aw2;
    assign o_dw     = use3 ? dw3   : dw2;
    assign o_res    = use3 ? res3  : res2;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_freeze"}, 32'(o_freeze), 0);
        check_val({tag, "_mis"},    32'(o_me), 0);
        check_val({tag, "_wben"},   32'(o_wbwb), 0);
        check_val({tag, "_rden"},   32'(o_rwb), 0);
        check_val({tag, "_alu"},    o_aw, 0);
        check_val({tag, "_dmem"},   o_dw, 0);
        check_val({tag, "_dest"},   32'(o_dwb), 0);
        check_val({tag, "_res"},    o_res, 0);
    endtask

    // Presents one instruction in IDLE and checks freeze, hazard outputs and WB results.
    task automatic issue(input int lat, input logic v, input logic [31:0] a, input logic [31:0] s,
                         input logic [4:0] d, input logic we, input logic rd, input logic wt);
        logic        is_mem, mis;
        logic [5:0]  idx;
        logic [31:0] old;
        in_valid = v; alu = a; st_val = s; dest = d; wb = we; re = rd; wr = wt;
        #1;
        check_val("idle_freeze", 32'(o_freeze), 0);
        check_val("idle_dest_mem", 32'(o_dm), 32'(d));
        check_val("idle_wben_mem", 32'(o_wbm), 32'(we & v));
        is_mem = v && (rd || wt);
        mis    = CHK && is_mem && (a[1:0] != 2'b00);
        idx    = a[7:2];
        old    = mem_m[idx];
        tick();
        in_valid = 1'b0; alu = $urandom; st_val = $urandom; dest = 5'($urandom);
        wb = 1'b1; re = 1'b1; wr = 1'b1;
        if (is_mem) begin
            for (int k = 1; k < lat; k++) begin
                check_val("busy_freeze", 32'(o_freeze), 1);
                check_val("busy_dest_mem", 32'(o_dm), 32'(d));
                check_val("busy_wben_mem", 32'(o_wbm), 32'(we));
                check_val("busy_bubble", 32'(o_wbwb), 0);
                tick();
            end
        end
        check_val("wb_freeze", 32'(o_freeze), 0);
        if (v) begin
            check_val("wb_wben", 32'(o_wbwb), 32'(we & !mis));
            check_val("wb_rden", 32'(o_rwb), 32'(rd));
            check_val("wb_dest", 32'(o_dwb), 32'(d));
            check_val("wb_result", o_res, rd ? old : a);
            check_val("wb_mis", 32'(o_me), 32'(mis));
        end else begin
            check_val("bubble_wben", 32'(o_wbwb), 0);
            check_val("bubble_rden", 32'(o_rwb), 0);
            check_val("bubble_mis", 32'(o_me), 0);
        end
        if (is_mem && wt && !mis) mem_m[idx] = s;
    endtask

    // Starts a 3-cycle access on dut3 and resets it in the second freeze cycle.
    task automatic abort3(input logic [31:0] a, input logic [31:0] s, input logic rd, input logic wt);
        in_valid = 1'b1; alu = a; st_val = s; dest = 5'd9; wb = 1'b1; re = rd; wr = wt;
        tick();
        in_valid = 1'b0;
        check_val("abort_freeze1", 32'(o_freeze), 1);
        tick();
        check_val("abort_freeze2", 32'(o_freeze), 1);
        rst3 = 1'b1;
        tick();
        rst3 = 1'b0;
        check_reset("abort");
    endtask

    initial begin
        rst2 = 1'b1; rst3 = 1'b1; use3 = 1'b0;
        in_valid = 1'b0; alu = '0; st_val = '0; dest = '0; wb = 1'b0; re = 1'b0; wr = 1'b0;
        tick(); tick();
        check_reset("rst2");
        rst2 = 1'b0;

        issue(2, 1'b1, 32'h0000_0055, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0);
        issue(2, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 1'b1);
        issue(2, 1'b1, 32'h0000_0010, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0);
        issue(2, 1'b1, 32'h0000_0110, 32'h600D_F00D, 5'd0, 1'b0, 1'b0, 1'b1);
        issue(2, 1'b1, 32'h0000_0010, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0);
        issue(2, 1'b1, 32'h0000_0012, 32'hBAD0_0BAD, 5'd0, 1'b0, 1'b0, 1'b1);
        issue(2, 1'b1, 32'h0000_0010, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0);
        issue(2, 1'b1, 32'h0000_0010, 32'h1111_2222, 5'd5, 1'b1, 1'b1, 1'b1);
        issue(2, 1'b1, 32'h0000_0010, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 64; i++)
            issue(2, 1'b1, {$urandom_range(0, 255), 6'(i), 2'b00} , $urandom, 5'd0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 300; i++) begin
            int          op;
            logic [31:0] a;
            op = $urandom_range(0, 4);
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            case (op)
                0:       issue(2, 1'b0, a, $urandom, 5'($urandom), 1'($urandom), 1'b0, 1'b0);
                1:       issue(2, 1'b1, a, $urandom, 5'($urandom), 1'($urandom), 1'b0, 1'b0);
                2:       issue(2, 1'b1, a, $urandom, 5'($urandom), 1'($urandom), 1'b1, 1'b0);
                3:       issue(2, 1'b1, a, $urandom, 5'($urandom), 1'($urandom), 1'b0, 1'b1);
                default: issue(2, 1'b1, a, $urandom, 5'($urandom), 1'($urandom), 1'b1, 1'b1);
            endcase
        end

        use3 = 1'b1;
        rst3 = 1'b1;
        tick();
        rst3 = 1'b0;
        check_reset("rst3");
        issue(3, 1'b1, 32'h0000_0014, 32'h1234_5678, 5'd0, 1'b0, 1'b0, 1'b1);
        abort3(32'h0000_0014, 32'h0, 1'b1, 1'b0);
        abort3(32'h0000_0014, 32'hCAFE_F00D, 1'b0, 1'b1);
        issue(3, 1'b1, 32'h0000_0014, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0);
        issue(3, 1'b1, 32'h0000_0018, 32'hA5A5_5A5A, 5'd0, 1'b0, 1'b0, 1'b1);
        issue(3, 1'b1, 32'h0000_0018, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0);
        issue(3, 1'b1, 32'h0000_0077, 32'h0, 5'd12, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
